// File: rtl/ysyx_22050612_mcyc_ctrl_if.sv
// Bundle of fetch, decode, data-memory, writeback and status signals around the
// multi-cycle controller. The controller connects through the master modport.
interface ysyx_22050612_mcyc_ctrl_if;
  // instruction fetch
  logic        ifu_req;
  logic        ifu_ack;
  logic        inst_we;
  // decoded instruction fields (held stable by the decode latch)
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_wen;
  logic [4:0]  dec_rd;
  logic        dec_ebreak;
  logic        dec_illegal;
  // data memory
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_ack;
  // writeback and commit
  logic        rf_wen;
  logic        pc_we;
  // status and performance counters
  logic        halted;
  logic        err;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  modport master (
    output ifu_req, inst_we, lsu_req, lsu_we, rf_wen, pc_we,
    output halted, err, mcycle, minstret,
    input  ifu_ack, dec_is_load, dec_is_store, dec_wen, dec_rd,
    input  dec_ebreak, dec_illegal, lsu_ack
  );

  modport slave (
    input  ifu_req, inst_we, lsu_req, lsu_we, rf_wen, pc_we,
    input  halted, err, mcycle, minstret,
    output ifu_ack, dec_is_load, dec_is_store, dec_wen, dec_rd,
    output dec_ebreak, dec_illegal, lsu_ack
  );
endinterface

// File: rtl/ysyx_22050612_mcyc_ctrl.sv
// Multi-cycle core sequencer: FETCH -> DECODE -> (MEM) -> WB, with a request
// timeout watchdog, sticky halt/error status and 64-bit cycle/retire counters.
module ysyx_22050612_mcyc_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050612_mcyc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // A wait of TIMEOUT unacknowledged cycles ends when the counter, which
  // starts at 0, is at TIMEOUT-1 in a cycle that still sees no ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_q     <= 8'd0;
      err_q      <= 1'b0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.ifu_ack) begin
          state_d = S_DECODE;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          wait_d  = 8'd0;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        wait_d = 8'd0;
        if (bus.dec_illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (bus.dec_ebreak) begin
          state_d = S_HALT;
          err_d   = 1'b0;
        end else if (bus.dec_is_load || bus.dec_is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (bus.lsu_ack) begin
          state_d = S_WB;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          wait_d  = 8'd0;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end

      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        // unreachable encodings park the core as a fault
        state_d = S_HALT;
        err_d   = 1'b1;
        wait_d  = 8'd0;
      end
    endcase
  end

  // counters wrap silently; mcycle stops once the core is halted
  always_comb begin
    mcycle_d   = (state_q == S_HALT) ? mcycle_q : mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire};
  end

  // Every output is gated by rst so that nothing is visible during reset.
  logic in_fetch, in_mem, in_wb, in_halt, run;

  assign run      = ~rst;
  assign in_fetch = run & (state_q == S_FETCH);
  assign in_mem   = run & (state_q == S_MEM);
  assign in_wb    = run & (state_q == S_WB);
  assign in_halt  = run & (state_q == S_HALT);

  assign bus.ifu_req  = in_fetch;
  assign bus.inst_we  = in_fetch & bus.ifu_ack;
  assign bus.lsu_req  = in_mem;
  assign bus.lsu_we   = in_mem & bus.dec_is_store;
  assign bus.pc_we    = in_wb;
  assign bus.rf_wen   = in_wb & bus.dec_wen & ~bus.dec_is_store & (bus.dec_rd != 5'd0);
  assign bus.halted   = in_halt;
  assign bus.err      = run & err_q;
  assign bus.mcycle   = run ? mcycle_q : 64'd0;
  assign bus.minstret = run ? minstret_q : 64'd0;

endmodule

// File: tb/tb_ysyx_22050612_mcyc_ctrl.sv
// Directed checks of the multi-cycle controller: one instance with the default
// timeout and one with TIMEOUT=3 for the watchdog boundaries.
module tb_ysyx_22050612_mcyc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ysyx_22050612_mcyc_ctrl_if bus_a ();
  ysyx_22050612_mcyc_ctrl_if bus_b ();

  ysyx_22050612_mcyc_ctrl #(.TIMEOUT(255)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ysyx_22050612_mcyc_ctrl #(.TIMEOUT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // each cycle window opens 1 time unit after the falling edge
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic dec_a(input logic ld, input logic st, input logic wen,
                       input logic [4:0] rd, input logic ebrk, input logic ill);
    bus_a.dec_is_load  = ld;
    bus_a.dec_is_store = st;
    bus_a.dec_wen      = wen;
    bus_a.dec_rd       = rd;
    bus_a.dec_ebreak   = ebrk;
    bus_a.dec_illegal  = ill;
  endtask

  task automatic clear_inputs();
    bus_a.ifu_ack = 1'b0;
    bus_a.lsu_ack = 1'b0;
    dec_a(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus_b.ifu_ack      = 1'b0;
    bus_b.lsu_ack      = 1'b0;
    bus_b.dec_is_load  = 1'b0;
    bus_b.dec_is_store = 1'b0;
    bus_b.dec_wen      = 1'b0;
    bus_b.dec_rd       = 5'd0;
    bus_b.dec_ebreak   = 1'b0;
    bus_b.dec_illegal  = 1'b0;
  endtask

  // hold rst across one rising edge, check forced-zero outputs, then release
  task automatic do_reset(input string tag);
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    check({tag, "_rst_ifu_req"},  {63'd0, bus_a.ifu_req}, 64'd0);
    check({tag, "_rst_halted"},   {63'd0, bus_a.halted},  64'd0);
    check({tag, "_rst_err"},      {63'd0, bus_a.err},     64'd0);
    check({tag, "_rst_mcycle"},   bus_a.mcycle,           64'd0);
    check({tag, "_rst_minstret"}, bus_a.minstret,         64'd0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();

    // ---- ALU op, rd=5 ----
    do_reset("alu");
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    check("alu_c1_ifu_req", {63'd0, bus_a.ifu_req}, 64'd1);
    check("alu_c1_inst_we", {63'd0, bus_a.inst_we}, 64'd1);
    check("alu_c1_mcycle",  bus_a.mcycle, 64'd0);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    #1;
    check("alu_c2_ifu_req", {63'd0, bus_a.ifu_req}, 64'd0);
    check("alu_c2_pc_we",   {63'd0, bus_a.pc_we},   64'd0);
    next_cycle();
    check("alu_c3_rf_wen",   {63'd0, bus_a.rf_wen}, 64'd1);
    check("alu_c3_pc_we",    {63'd0, bus_a.pc_we},  64'd1);
    check("alu_c3_minstret", bus_a.minstret, 64'd0);
    check("alu_c3_mcycle",   bus_a.mcycle,   64'd2);
    next_cycle();
    check("alu_c4_ifu_req",  {63'd0, bus_a.ifu_req}, 64'd1);
    check("alu_c4_minstret", bus_a.minstret, 64'd1);
    $display("alu op retired, minstret=%0d", bus_a.minstret);

    // ---- rd=0 suppresses the register write (cycles 4..6) ----
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    next_cycle();
    check("rd0_rf_wen", {63'd0, bus_a.rf_wen}, 64'd0);
    check("rd0_pc_we",  {63'd0, bus_a.pc_we},  64'd1);
    next_cycle();
    check("rd0_minstret", bus_a.minstret, 64'd2);
    $display("rd0 op retired, minstret=%0d", bus_a.minstret);

    // ---- load with lsu_ack delayed 4 cycles (cycle 7 onward) ----
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    next_cycle();
    next_cycle();                        // first MEM cycle; ifu_ack stays high and must be ignored
    for (int i = 0; i < 5; i++) begin
      bus_a.lsu_ack = (i == 4);
      #1;
      check($sformatf("ld_mem%0d_lsu_req", i), {63'd0, bus_a.lsu_req}, 64'd1);
      check($sformatf("ld_mem%0d_lsu_we", i),  {63'd0, bus_a.lsu_we},  64'd0);
      check($sformatf("ld_mem%0d_inst_we", i), {63'd0, bus_a.inst_we}, 64'd0);
      check($sformatf("ld_mem%0d_pc_we", i),   {63'd0, bus_a.pc_we},   64'd0);
      next_cycle();
    end
    bus_a.lsu_ack = 1'b0;
    bus_a.ifu_ack = 1'b0;
    #1;
    check("ld_wb_lsu_req", {63'd0, bus_a.lsu_req}, 64'd0);
    check("ld_wb_rf_wen",  {63'd0, bus_a.rf_wen},  64'd1);
    check("ld_wb_pc_we",   {63'd0, bus_a.pc_we},   64'd1);
    next_cycle();
    check("ld_minstret",   bus_a.minstret, 64'd3);
    check("ld_mcycle",     bus_a.mcycle,   64'd14);
    $display("load retired, minstret=%0d mcycle=%0d", bus_a.minstret, bus_a.mcycle);

    // ---- store, same-cycle acks: 4 cycles (cycle 15 onward) ----
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    next_cycle();
    bus_a.lsu_ack = 1'b1;
    #1;
    check("st_lsu_req", {63'd0, bus_a.lsu_req}, 64'd1);
    check("st_lsu_we",  {63'd0, bus_a.lsu_we},  64'd1);
    next_cycle();
    bus_a.lsu_ack = 1'b0;
    #1;
    check("st_rf_wen", {63'd0, bus_a.rf_wen}, 64'd0);
    check("st_pc_we",  {63'd0, bus_a.pc_we},  64'd1);
    next_cycle();
    check("st_minstret", bus_a.minstret, 64'd4);
    check("st_mcycle",   bus_a.mcycle,   64'd18);
    $display("store retired, minstret=%0d mcycle=%0d", bus_a.minstret, bus_a.mcycle);

    // ---- ebreak halts cleanly (cycle 19 onward) ----
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    next_cycle();
    check("ebrk_halted", {63'd0, bus_a.halted}, 64'd1);
    check("ebrk_err",    {63'd0, bus_a.err},    64'd0);
    check("ebrk_mcycle", bus_a.mcycle, 64'd20);
    for (int i = 0; i < 3; i++) begin
      bus_a.ifu_ack = i[0] ? 1'b0 : 1'b1;
      #1;
      check($sformatf("halt%0d_ifu_req", i), {63'd0, bus_a.ifu_req}, 64'd0);
      check($sformatf("halt%0d_inst_we", i), {63'd0, bus_a.inst_we}, 64'd0);
      next_cycle();
    end
    bus_a.ifu_ack = 1'b0;
    check("halt_still_halted", {63'd0, bus_a.halted}, 64'd1);
    check("halt_mcycle_frozen", bus_a.mcycle,   64'd20);
    check("halt_minstret",      bus_a.minstret, 64'd4);
    $display("ebreak halt, mcycle=%0d", bus_a.mcycle);

    // ---- illegal wins over ebreak ----
    do_reset("ill");
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    next_cycle();
    check("ill_halted", {63'd0, bus_a.halted}, 64'd1);
    check("ill_err",    {63'd0, bus_a.err},    64'd1);
    $display("illegal halt, err=%0d", bus_a.err);

    // ---- reset in the middle of a data access ----
    do_reset("rmem");
    bus_a.ifu_ack = 1'b1;
    dec_a(1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    next_cycle();
    bus_a.ifu_ack = 1'b0;
    next_cycle();
    check("rmem_in_mem", {63'd0, bus_a.lsu_req}, 64'd1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rmem_lsu_req", {63'd0, bus_a.lsu_req}, 64'd0);
    check("rmem_ifu_req", {63'd0, bus_a.ifu_req}, 64'd0);
    check("rmem_pc_we",   {63'd0, bus_a.pc_we},   64'd0);
    check("rmem_rf_wen",  {63'd0, bus_a.rf_wen},  64'd0);
    check("rmem_mcycle",  bus_a.mcycle, 64'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rmem_after_ifu_req",  {63'd0, bus_a.ifu_req}, 64'd1);
    check("rmem_after_lsu_req",  {63'd0, bus_a.lsu_req}, 64'd0);
    check("rmem_after_mcycle",   bus_a.mcycle,   64'd0);
    check("rmem_after_minstret", bus_a.minstret, 64'd0);
    $display("reset during MEM recovered to FETCH");

    // ---- TIMEOUT=3: fetch with no ack halts after 3 FETCH cycles ----
    do_reset("tmo");
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("tmo_f%0d_ifu_req", i), {63'd0, bus_b.ifu_req}, 64'd1);
      check($sformatf("tmo_f%0d_halted", i),  {63'd0, bus_b.halted},  64'd0);
      next_cycle();
    end
    check("tmo_halted",  {63'd0, bus_b.halted},  64'd1);
    check("tmo_err",     {63'd0, bus_b.err},     64'd1);
    check("tmo_ifu_req", {63'd0, bus_b.ifu_req}, 64'd0);
    $display("fetch timeout, err=%0d", bus_b.err);

    // ---- TIMEOUT=3: ack on the 3rd FETCH cycle wins, then data timeout ----
    do_reset("tack");
    next_cycle();
    next_cycle();
    bus_b.ifu_ack = 1'b1;
    #1;
    check("tack_inst_we", {63'd0, bus_b.inst_we}, 64'd1);
    next_cycle();
    bus_b.ifu_ack = 1'b0;
    #1;
    check("tack_decode_halted",  {63'd0, bus_b.halted},  64'd0);
    check("tack_decode_ifu_req", {63'd0, bus_b.ifu_req}, 64'd0);
    next_cycle();
    check("tack_wb_pc_we", {63'd0, bus_b.pc_we}, 64'd1);
    next_cycle();
    bus_b.ifu_ack     = 1'b1;
    bus_b.dec_is_load = 1'b1;
    next_cycle();
    bus_b.ifu_ack = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mtmo_m%0d_lsu_req", i), {63'd0, bus_b.lsu_req}, 64'd1);
      next_cycle();
    end
    check("mtmo_halted",  {63'd0, bus_b.halted},  64'd1);
    check("mtmo_err",     {63'd0, bus_b.err},     64'd1);
    check("mtmo_lsu_req", {63'd0, bus_b.lsu_req}, 64'd0);
    $display("data timeout, err=%0d", bus_b.err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mcyc_ctrl.md
YSYX_22050612_MCYC_CTRL -- requirements
Module: ysyx_22050612_mcyc_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles a memory request may wait for ack before trap (1..255).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Port clk is the clock; port rst is the reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ifu_req  out  1  instruction fetch request.
REQ-006 ifu_ack  in  1  fetch complete; instruction valid this cycle.
REQ-007 inst_we  out  1  strobe: capture instruction into decode latch.
REQ-008 dec_is_load  in  1  decoded instruction is a load.
REQ-009 dec_is_store  in  1  decoded instruction is a store.
REQ-010 dec_wen  in  1  decoded instruction writes rd.
REQ-011 dec_rd  in  5  destination register index.
REQ-012 dec_ebreak  in  1  decoded instruction is ebreak.
REQ-013 dec_illegal  in  1  opcode not recognised.
REQ-014 lsu_req  out  1  data memory request.
REQ-015 lsu_we  out  1  data request is a write.
REQ-016 lsu_ack  in  1  data access complete.
REQ-017 rf_wen  out  1  register-file write enable.
REQ-018 pc_we  out  1  commit dnpc into PC.
REQ-019 halted  out  1  core stopped.
REQ-020 err  out  1  stop cause is illegal instruction or timeout.
REQ-021 mcycle  out  64  cycles executed since reset.
REQ-022 minstret  out  64  instructions retired since reset.

Function
REQ-023 States: FETCH, DECODE, MEM, WB, HALT; state register updates only on rising clk.
REQ-024 FETCH: ifu_req=1; on ifu_ack -> DECODE with inst_we=1 in the ack cycle; otherwise stay.
REQ-025 DECODE (exactly 1 cycle), priority: dec_illegal -> HALT err=1; dec_ebreak -> HALT err=0; load or store -> MEM; else -> WB.
REQ-026 MEM: lsu_req=1, lsu_we=dec_is_store; on lsu_ack -> WB; otherwise stay.
REQ-027 WB (exactly 1 cycle): pc_we=1; rf_wen = dec_wen & ~dec_is_store & (dec_rd != 0); minstret += 1; -> FETCH.
REQ-028 HALT: absorbing; halted=1; all request/strobe outputs 0; only rst exits.
REQ-029 Minimum latency with same-cycle acks: ALU op 3 cycles (FETCH, DECODE, WB); load/store 4 cycles.
REQ-030 ifu_req, lsu_req, lsu_we held stable until ack is sampled; ack in any other state is ignored.
REQ-031 Wait counter (8-bit): cleared on state entry; increments each FETCH/MEM cycle without ack; reaching TIMEOUT with no ack -> HALT err=1.
REQ-032 Ack in the same cycle the wait counter reaches TIMEOUT: ack wins, normal transition.
REQ-033 mcycle increments every cycle rst=0 and state != HALT; freezes in HALT.
REQ-034 mcycle and minstret wrap modulo 2^64 to 0 with no flag.
REQ-035 err is written only on HALT entry and holds thereafter.
REQ-036 All outputs are decoded from registered state and counters; no combinational path from dec_* to ifu_req.

Reset
REQ-037 rst=1 at a rising edge: state=FETCH; mcycle=0; minstret=0; wait counter=0; halted=0; err=0.
REQ-038 While rst=1 all outputs are forced 0, including ifu_req.
REQ-039 rst mid-MEM or mid-FETCH abandons the access with no pc_we or rf_wen; the first cycle after rst falls is FETCH with ifu_req=1.

Verification
REQ-040 ALU op, ifu_ack on first FETCH cycle, dec_wen=1, dec_rd=5 -> inst_we cycle 1, rf_wen=1 and pc_we=1 cycle 3, minstret=1.
REQ-041 Load, lsu_ack delayed 4 cycles -> lsu_req=1 and lsu_we=0 for 5 cycles, then one WB; store -> lsu_we=1 and rf_wen=0.
REQ-042 dec_wen=1 with dec_rd=0 -> rf_wen=0, pc_we=1.
REQ-043 dec_ebreak -> halted=1, err=0; mcycle frozen; ifu_ack pulses ignored. dec_illegal=1 with dec_ebreak=1 -> err=1.
REQ-044 TIMEOUT=3, ifu_ack held 0 -> HALT err=1 after 3 FETCH cycles; repeat with ack on the 3rd cycle -> DECODE.
REQ-045 rst asserted during MEM -> lsu_req=0, counters 0; next cycle FETCH with ifu_req=1.
